lp_scan_solver: RTL and testbench

- Parametrised brute-force integer linear-program solver: maximise c1*x1 + c2*x2 subject to NUM_CON constraints a1*x1 + a2*x2 <= b.
- The feasible box is taken from the four axis-bound constraints in the set; every lattice point in the box is scanned, one per cycle.
- Reports the maximum objective, the first maximising point, a feasibility flag and an error flag.
- Next-generation LP block: adds a constraint-count parameter, argmax output, infeasible/error reporting and an input ready handshake.

---
 rtl/lp_pkg.sv | 22 ++
 rtl/lp_con_check.sv | 46 ++++
 rtl/lp_scan_solver.sv | 233 +++++++++++++++++++++++
 tb/tb_lp_scan_solver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared types and default widths for the brute-force integer LP scan solver.
package lp_pkg;

  localparam int LP_NUM_CON = 6;
  localparam int LP_A_W     = 6;
  localparam int LP_B_W     = 12;
  localparam int LP_OBJ_W   = LP_A_W + LP_B_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [LP_A_W-1:0] a1;
    logic signed [LP_A_W-1:0] a2;
    logic signed [LP_B_W-1:0] b;
  } con_t;

endpackage

// File: rtl/lp_con_check.sv
// Combinational check of one lattice point against every stored constraint, plus its objective value.
// Zero latency; no flow control of its own.
module lp_con_check
  import lp_pkg::*;
#(
  parameter int NUM_CON = LP_NUM_CON,
  parameter int A_W     = LP_A_W,
  parameter int B_W     = LP_B_W,
  parameter int OBJ_W   = A_W + B_W + 1
) (
  input  logic signed [A_W-1:0]   c1_i,
  input  logic signed [A_W-1:0]   c2_i,
  input  logic signed [B_W-1:0]   x1_i,
  input  logic signed [B_W-1:0]   x2_i,
  input  con_t [NUM_CON-1:0]      cons_i,
  output logic                    feasible_o,
  output logic signed [OBJ_W-1:0] obj_o
);

  // Operands are sign-extended to OBJ_W first, so neither product nor sum can overflow.
  function automatic logic signed [OBJ_W-1:0] dot2(
    input logic signed [A_W-1:0] p,
    input logic signed [A_W-1:0] q,
    input logic signed [B_W-1:0] u,
    input logic signed [B_W-1:0] v
  );
    logic signed [OBJ_W-1:0] pe, qe, ue, ve;
    pe = OBJ_W'(p);
    qe = OBJ_W'(q);
    ue = OBJ_W'(u);
    ve = OBJ_W'(v);
    return pe * ue + qe * ve;
  endfunction

  always_comb begin
    feasible_o = 1'b1;
    for (int i = 0; i < NUM_CON; i++) begin
      if (dot2(cons_i[i].a1, cons_i[i].a2, x1_i, x2_i) > OBJ_W'(cons_i[i].b)) begin
        feasible_o = 1'b0;
      end
    end
  end

  assign obj_o = dot2(c1_i, c2_i, x1_i, x2_i);

endmodule

// File: rtl/lp_scan_solver.sv
// Loads an objective beat plus NUM_CON constraint beats, then scans the bounded box one point per cycle.
// out_valid comes box_size+2 cycles after the last beat (2 on error); in_ready is high only in IDLE.
module lp_scan_solver
  import lp_pkg::*;
#(
  parameter int NUM_CON = LP_NUM_CON,
  parameter int A_W     = LP_A_W,
  parameter int B_W     = LP_B_W,
  parameter int OBJ_W   = A_W + B_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   in_a1,
  input  logic signed [A_W-1:0]   in_a2,
  input  logic signed [B_W-1:0]   in_b,
  output logic                    out_valid,
  output logic signed [OBJ_W-1:0] out_max_value,
  output logic signed [B_W-1:0]   out_x1,
  output logic signed [B_W-1:0]   out_x2,
  output logic                    out_feasible,
  output logic                    out_err
);

  localparam int BEAT_W = $clog2(NUM_CON + 1);
  localparam logic signed [OBJ_W-1:0] OBJ_MIN = {1'b1, {(OBJ_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    setup_q, setup_d;
  logic signed [A_W-1:0]   c1_q, c1_d, c2_q, c2_d;
  con_t [NUM_CON-1:0]      cons_q, cons_d;
  logic signed [B_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic signed [B_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [3:0]              seen_q, seen_d;
  logic signed [B_W-1:0]   x1_q, x1_d, x2_q, x2_d;
  logic signed [OBJ_W-1:0] best_q, best_d;
  logic signed [B_W-1:0]   bx1_q, bx1_d, bx2_q, bx2_d;
  logic                    found_q, found_d;
  logic signed [OBJ_W-1:0] max_q, max_d;
  logic signed [B_W-1:0]   ox1_q, ox1_d, ox2_q, ox2_d;
  logic                    feas_q, feas_d, err_q, err_d;

  logic                    pt_feasible;
  logic signed [OBJ_W-1:0] pt_obj;
  logic                    upd;

  lp_con_check #(
    .NUM_CON (NUM_CON),
    .A_W     (A_W),
    .B_W     (B_W),
    .OBJ_W   (OBJ_W)
  ) u_con_check (
    .c1_i       (c1_q),
    .c2_i       (c2_q),
    .x1_i       (x1_q),
    .x2_i       (x2_q),
    .cons_i     (cons_q),
    .feasible_o (pt_feasible),
    .obj_o      (pt_obj)
  );

  // Strict compare keeps the earliest point in scan order on ties.
  assign upd = pt_feasible && (!found_q || (pt_obj > best_q));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    setup_d = setup_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    cons_d  = cons_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    seen_d  = seen_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    best_d  = best_q;
    bx1_d   = bx1_q;
    bx2_d   = bx2_q;
    found_d = found_q;
    max_d   = max_q;
    ox1_d   = ox1_q;
    ox2_d   = ox2_q;
    feas_d  = feas_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          c1_d    = in_a1;
          c2_d    = in_a2;
          beat_d  = BEAT_W'(1);
          seen_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_CON; i++) begin
            if (beat_q == BEAT_W'(i + 1)) cons_d[i] = '{a1: in_a1, a2: in_a2, b: in_b};
          end
          // Axis-bound rows define the scan box; seen_q = {ymin, ymax, xmin, xmax}.
          if (in_a2 == '0 && in_a1 == A_W'(1)) begin
            xmax_d    = in_b;
            seen_d[0] = 1'b1;
          end
          if (in_a2 == '0 && in_a1 == '1) begin
            xmin_d    = -in_b;
            seen_d[1] = 1'b1;
          end
          if (in_a1 == '0 && in_a2 == A_W'(1)) begin
            ymax_d    = in_b;
            seen_d[2] = 1'b1;
          end
          if (in_a1 == '0 && in_a2 == '1) begin
            ymin_d    = -in_b;
            seen_d[3] = 1'b1;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(NUM_CON)) begin
            state_d = ST_SCAN;
            setup_d = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (setup_q) begin
          setup_d = 1'b0;
          found_d = 1'b0;
          best_d  = OBJ_MIN;
          if (!(&seen_q) || (xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
            state_d = ST_DONE;
            max_d   = '0;
            ox1_d   = '0;
            ox2_d   = '0;
            feas_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            x1_d = xmin_q;
            x2_d = ymin_q;
          end
        end else begin
          if (upd) begin
            best_d  = pt_obj;
            bx1_d   = x1_q;
            bx2_d   = x2_q;
            found_d = 1'b1;
          end
          if (x1_q == xmax_q) begin
            x1_d = xmin_q;
            if (x2_q == ymax_q) begin
              state_d = ST_DONE;
              max_d   = found_d ? best_d : '0;
              ox1_d   = found_d ? bx1_d : '0;
              ox2_d   = found_d ? bx2_d : '0;
              feas_d  = found_d;
              err_d   = 1'b0;
            end else begin
              x2_d = x2_q + B_W'(1);
            end
          end else begin
            x1_d = x1_q + B_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      setup_q <= 1'b0;
      c1_q    <= '0;
      c2_q    <= '0;
      cons_q  <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      seen_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      best_q  <= '0;
      bx1_q   <= '0;
      bx2_q   <= '0;
      found_q <= 1'b0;
      max_q   <= '0;
      ox1_q   <= '0;
      ox2_q   <= '0;
      feas_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      setup_q <= setup_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      cons_q  <= cons_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      seen_q  <= seen_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      best_q  <= best_d;
      bx1_q   <= bx1_d;
      bx2_q   <= bx2_d;
      found_q <= found_d;
      max_q   <= max_d;
      ox1_q   <= ox1_d;
      ox2_q   <= ox2_d;
      feas_q  <= feas_d;
      err_q   <= err_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_DONE);
  assign out_max_value = max_q;
  assign out_x1        = ox1_q;
  assign out_x2        = ox2_q;
  assign out_feasible  = feas_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_lp_scan_solver.sv
// Scoreboard bench for lp_scan_solver: expected results are queued per problem and matched on out_valid.
module tb_lp_scan_solver;

  localparam int NC = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [5:0]  in_a1, in_a2;
  logic signed [11:0] in_b;
  logic               out_valid;
  logic signed [18:0] out_max_value;
  logic signed [11:0] out_x1, out_x2;
  logic               out_feasible, out_err;

  lp_scan_solver dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a1         (in_a1),
    .in_a2         (in_a2),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_max_value (out_max_value),
    .out_x1        (out_x1),
    .out_x2        (out_x2),
    .out_feasible  (out_feasible),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint mx;
    longint x1;
    longint x2;
    int     feas;
    int     err;
    int     lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_cyc = 0;

  logic signed [5:0]  ta1[NC];
  logic signed [5:0]  ta2[NC];
  logic signed [11:0] tbv[NC];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        check("max_value", 64'(out_max_value), e.mx);
        check("x1", 64'(out_x1), e.x1);
        check("x2", 64'(out_x2), e.x2);
        check("feasible", 64'(out_feasible), 64'(e.feas));
        check("err", 64'(out_err), 64'(e.err));
        check("latency", 64'(cyc - last_cyc), 64'(e.lat));
      end
    end
  end

  task automatic set_con(input int i, input int a1, input int a2, input int b);
    ta1[i] = 6'(a1);
    ta2[i] = 6'(a2);
    tbv[i] = 12'(b);
  endtask

  task automatic set_basic();
    set_con(0, 1, 0, 4);   set_con(1, -1, 0, 0);
    set_con(2, 0, 1, 3);   set_con(3, 0, -1, 0);
    set_con(4, 1, 1, 5);   set_con(5, 2, -1, 6);
  endtask

  task automatic expect_res(input longint mx, input longint x1, input longint x2,
                            input int feas, input int err, input int lat);
    exp_t e;
    e.mx = mx; e.x1 = x1; e.x2 = x2; e.feas = feas; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called and returns at a negedge; gap>0 inserts idle cycles before even-numbered constraint beats.
  task automatic send(input int c1, input int c2, input int gap);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_send", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_a1 = 6'(c1);
    in_a2 = 6'(c2);
    in_b  = 12'(0);
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      if (i == 0) check("in_ready_load", 64'(in_ready), 64'(0));
      if (gap > 0 && (i % 2) == 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_a1 = ta1[i];
      in_a2 = ta2[i];
      in_b  = tbv[i];
      if (i == NC - 1) last_cyc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("result_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a1 = '0;
    in_a2 = '0;
    in_b  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_max", 64'(out_max_value), 64'(0));
    check("rst_x1", 64'(out_x1), 64'(0));
    check("rst_x2", 64'(out_x2), 64'(0));
    check("rst_feasible", 64'(out_feasible), 64'(0));
    check("rst_err", 64'(out_err), 64'(0));
    rst_n = 1'b1;

    // Basic: box 0..4 x 0..3 (20 points)
    set_basic();
    expect_res(13, 3, 2, 1, 0, 22);
    send(3, 2, 0);
    wait_empty();

    // Same problem with gapped load beats
    expect_res(13, 3, 2, 1, 0, 22);
    send(3, 2, 2);
    wait_empty();

    // Negative box: x -3..-1, y -2..2 (15 points)
    set_con(0, 1, 0, -1);  set_con(1, -1, 0, 3);
    set_con(2, 0, 1, 2);   set_con(3, 0, -1, 2);
    set_con(4, 1, 1, 10);  set_con(5, 1, 1, 10);
    expect_res(5, -3, -2, 1, 0, 17);
    send(-1, -1, 0);
    wait_empty();

    // Infeasible: box 0..2 x 0..2 with x1+x2 <= -1
    set_con(0, 1, 0, 2);   set_con(1, -1, 0, 0);
    set_con(2, 0, 1, 2);   set_con(3, 0, -1, 0);
    set_con(4, 1, 1, -1);  set_con(5, 1, 0, 2);
    expect_res(0, 0, 0, 0, 0, 11);
    send(1, 1, 0);
    wait_empty();

    // Missing ymin bound -> error, 2 cycles after last beat
    set_basic();
    set_con(3, 1, 1, 9);
    expect_res(0, 0, 0, 0, 1, 2);
    send(3, 2, 0);
    wait_empty();

    // Zero objective: every feasible point ties, earliest (0,0) must win
    set_con(0, 1, 0, 2);   set_con(1, -1, 0, 0);
    set_con(2, 0, 1, 2);   set_con(3, 0, -1, 0);
    set_con(4, 1, 1, 10);  set_con(5, 1, 1, 10);
    expect_res(0, 0, 0, 1, 0, 11);
    send(0, 0, 0);
    wait_empty();

    // in_valid during SCAN is ignored
    set_basic();
    expect_res(13, 3, 2, 1, 0, 22);
    send(3, 2, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a1 = 6'(i + 1);
      in_a2 = 6'(-i);
      in_b  = 12'(7 * i);
      @(negedge clk);
      check("in_ready_scan", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    check("hold_max", 64'(out_max_value), 64'(13));
    check("hold_feasible", 64'(out_feasible), 64'(1));

    // Reset in the middle of a scan: no result, then a clean solve
    send(3, 2, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_max", 64'(out_max_value), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'(1));
    expect_res(13, 3, 2, 1, 0, 22);
    send(3, 2, 0);
    wait_empty();

    check("pending_results", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
